fft_stream_engine: RTL and testbench
====================================

// Module: fft_stream_engine
// PURPOSE
//  Streaming successor to the combinational FFT top. Accepts time-domain samples one per beat (valid/ready).
//  Packs them into ping-pong frame buffers and runs each full frame through FFT_N_Point + Partial_Magnitude_Computer.
//  Emits partial magnitudes (no sqrt) one bin per beat on a valid/ready stream.
//  Adds full- or half-spectrum output mode, a multicycle compute window and a frame counter.
// PARAMETERS
//  SAMPLE_SIZE     16  bits per signed input sample and per output magnitude
//  BUFFER_SIZE     64  FFT points N; power of two, >=4
//  TWIDDLE_SIZE    16  twiddle word width passed to FFT_N_Point
//  COMPUTE_CYCLES  2   cycles the core input is held before results are captured (multicycle path), >=1
//  FCNT_SIZE       16  frame counter width
// PORTS
//  clk            in   1                  system clock
//  reset          in   1                  synchronous, active-high
//  in_sample      in   SAMPLE_SIZE        signed time-domain sample
//  in_valid       in   1                  in_sample valid
//  in_ready       out  1                  engine can accept a sample
//  half_spectrum  in   1                  1: emit bins 0..N/2 only; sampled at LOAD
//  out_mag        out  SAMPLE_SIZE        partial magnitude of current bin
//  out_bin        out  $clog2(N)          bin index of out_mag
//  out_valid      out  1                  out_mag/out_bin valid
//  out_ready      in   1                  downstream accepts beat
//  out_last       out  1                  last bin of the frame
//  frame_count    out  FCNT_SIZE          frames fully drained; wraps modulo 2^FCNT_SIZE
// BEHAVIOUR
//  Reset: all outputs 0; both buffers empty; wr_sel=rd_sel=0; wr_idx=0; FSM=IDLE; in_ready=0 while reset high.
//  Fill side:
//  - in_ready = !full[wr_sel].
//  - On in_valid&&in_ready: buf[wr_sel][wr_idx]<=in_sample. Sample k of a frame occupies bits [k*SAMPLE_SIZE +: SAMPLE_SIZE].
//  - On wr_idx==N-1: set full[wr_sel], toggle wr_sel, wr_idx<=0.
//  Engine FSM IDLE->LOAD->COMPUTE->DRAIN:
//  - IDLE: go LOAD when full[rd_sel].
//  - LOAD: core_in<=buf[rd_sel]; mode<=half_spectrum; cnt<=0; next COMPUTE.
//  - COMPUTE: cnt++. When cnt==COMPUTE_CYCLES-1:
//    - result<=core magnitudes; clear full[rd_sel]; toggle rd_sel; bin<=0.
//    - Next state DRAIN.
//  - DRAIN: out_valid=1; out_mag=result[bin]; out_bin=bin; out_last=(bin==last).
//    - last = N/2 if mode else N-1.
//    - On out_ready: bin++. At last: frame_count++.
//    - After last: go LOAD if full[rd_sel], else IDLE. No bubble required.
//  Latency: last input beat -> first out_valid = COMPUTE_CYCLES+2 cycles (buffer idle case).
//  Output stability: out_mag/out_bin/out_last held while out_valid&&!out_ready.
//  Buffer release at capture: next frame may fill during DRAIN. Up to 2N samples are accepted before in_ready drops.
//  Simultaneous fill-complete and engine release: touch different buffers; both take effect in the same cycle.
//  half_spectrum changes mid-frame: no effect until next LOAD.
//  Reset mid-operation: partial frames and pending results discarded; frame_count<=0.
//  Arithmetic is inherited from the sub-cores, with no extra scaling. out_mag is the low SAMPLE_SIZE bits of the core output.
// STRUCTURE
//  fft_pkg: SAMPLE_SIZE/BUFFER_SIZE/TWIDDLE_SIZE defaults; engine_state_t enum {IDLE,LOAD,COMPUTE,DRAIN}.
//  Sub-module fft_pingpong_buffer: two N-deep frame registers with full flags, write index and sel bits. Exports frame vector + full flags.
//  Top instantiates Twiddle_Storage, FFT_N_Point, Partial_Magnitude_Computer, the buffer and the FSM/drain logic.
// TESTING (N=8, SAMPLE_SIZE=16, COMPUTE_CYCLES=2)
//  1 Reset held 3 cycles -> in_ready=0, out_valid=0, frame_count=0; in_ready=1 the cycle after release.
//  2 Eight samples of +4, half=0, out_ready=1:
//    - 8 beats, bins 0..7.
//    - Bin 0 equals the reference-model magnitude of 32+0j; bins 1..7 = 0.
//    - out_last only on bin 7; frame_count=1.
//  3 Impulse (4,0,0,0,0,0,0,0), half=1:
//    - 5 beats, bins 0..4, all equal to the model magnitude of 4+0j.
//    - out_last on bin 4.
//  4 Back-pressure with out_ready low for 20 cycles after first out_valid:
//    - Outputs stable.
//    - Exactly 16 samples accepted, then in_ready=0 until the second frame's capture.
//  5 Reset asserted mid-DRAIN (bin 3) -> next cycle out_valid=0, frame_count=0. A fresh frame then drains normally from bin 0.
//  6 4 back-to-back frames, in_valid=out_ready=1:
//    - 32 output beats, in order, no lost/duplicated bins.
//    - frame_count=4.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, engine state encoding and the drain-length helper
package fft_pkg;

    localparam int DEF_SAMPLE_SIZE    = 16;
    localparam int DEF_BUFFER_SIZE    = 64;
    localparam int DEF_TWIDDLE_SIZE   = 16;
    localparam int DEF_COMPUTE_CYCLES = 2;
    localparam int DEF_FCNT_SIZE      = 16;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} engine_state_t;

    // index of the final bin emitted for a frame: DC..Nyquist in half mode, all bins otherwise
    function automatic int last_bin(input logic half, input int n);
        return half ? n / 2 : n - 1;
    endfunction

endpackage

// File: rtl/FFT_N_Point.sv
// FFT_N_Point: combinational N-point transform X[k] = sum x[n]*exp(-j*2*pi*n*k/N)
module FFT_N_Point #(
    parameter int N            = 64,
    parameter int SAMPLE_SIZE  = 16,
    parameter int TWIDDLE_SIZE = 16,
    parameter int ACC_SIZE     = 24
) (
    input  logic [N*SAMPLE_SIZE-1:0]  samples,
    input  logic [N*TWIDDLE_SIZE-1:0] tw_cos,
    input  logic [N*TWIDDLE_SIZE-1:0] tw_sin,
    output logic [N*ACC_SIZE-1:0]     re,
    output logic [N*ACC_SIZE-1:0]     im
);

    localparam int PW = SAMPLE_SIZE + TWIDDLE_SIZE;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (TWIDDLE_SIZE - 2);

    // sample times twiddle, rounded back to sample scale
    function automatic logic signed [ACC_SIZE-1:0] tmul(
        input logic signed [SAMPLE_SIZE-1:0]  x,
        input logic signed [TWIDDLE_SIZE-1:0] w
    );
        logic signed [PW-1:0] p;
        p = x * w + HALF;
        return ACC_SIZE'(p >>> (TWIDDLE_SIZE - 1));
    endfunction

    // every bin accumulates all N rounded products; twiddle index wraps as (n*k) mod N
    always_comb begin
        re = '0;
        im = '0;
        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < N; n++) begin
                re[k*ACC_SIZE +: ACC_SIZE] = re[k*ACC_SIZE +: ACC_SIZE]
                    + tmul(samples[n*SAMPLE_SIZE +: SAMPLE_SIZE], tw_cos[((n * k) % N)*TWIDDLE_SIZE +: TWIDDLE_SIZE]);
                im[k*ACC_SIZE +: ACC_SIZE] = im[k*ACC_SIZE +: ACC_SIZE]
                    - tmul(samples[n*SAMPLE_SIZE +: SAMPLE_SIZE], tw_sin[((n * k) % N)*TWIDDLE_SIZE +: TWIDDLE_SIZE]);
            end
        end
    end

endmodule

// File: rtl/Partial_Magnitude_Computer.sv
// Partial_Magnitude_Computer: re^2 + im^2 per bin (no square root), low MAG_SIZE bits
module Partial_Magnitude_Computer #(
    parameter int N        = 64,
    parameter int ACC_SIZE = 24,
    parameter int MAG_SIZE = 16
) (
    input  logic [N*ACC_SIZE-1:0] re,
    input  logic [N*ACC_SIZE-1:0] im,
    output logic [N*MAG_SIZE-1:0] mag
);

    // low bits of a square do not depend on sign or upper bits, so modular arithmetic is exact
    always_comb begin
        mag = '0;
        for (int k = 0; k < N; k++)
            mag[k*MAG_SIZE +: MAG_SIZE] = MAG_SIZE'(re[k*ACC_SIZE +: ACC_SIZE] * re[k*ACC_SIZE +: ACC_SIZE]
                                                  + im[k*ACC_SIZE +: ACC_SIZE] * im[k*ACC_SIZE +: ACC_SIZE]);
    end

endmodule

// File: rtl/Twiddle_Storage.sv
// Twiddle_Storage: constant table of cos/sin(2*pi*k/N) in signed Q(TWIDDLE_SIZE-1), rounded to nearest
module Twiddle_Storage #(
    parameter int N            = 64,
    parameter int TWIDDLE_SIZE = 16
) (
    output logic [N*TWIDDLE_SIZE-1:0] tw_cos,
    output logic [N*TWIDDLE_SIZE-1:0] tw_sin
);

    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = 2.0 ** (TWIDDLE_SIZE - 1) - 1.0;

    for (genvar k = 0; k < N; k++) begin : g_tw
        localparam real ANG   = 2.0 * PI * k / N;
        localparam int  C_VAL = int'($floor($cos(ANG) * SCALE + 0.5));
        localparam int  S_VAL = int'($floor($sin(ANG) * SCALE + 0.5));
        assign tw_cos[k*TWIDDLE_SIZE +: TWIDDLE_SIZE] = TWIDDLE_SIZE'(C_VAL);
        assign tw_sin[k*TWIDDLE_SIZE +: TWIDDLE_SIZE] = TWIDDLE_SIZE'(S_VAL);
    end

endmodule

// File: rtl/fft_pingpong_buffer.sv
// fft_pingpong_buffer: two N-sample frame registers; fill side writes wr_sel, engine reads/releases rd_sel
module fft_pingpong_buffer #(
    parameter int N           = 64,
    parameter int SAMPLE_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SAMPLE_SIZE-1:0]   in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     release_rd,
    output logic [N*SAMPLE_SIZE-1:0] frame,
    output logic [1:0]               full,
    output logic                     rd_sel
);

    localparam int IW = $clog2(N);

    logic [N*SAMPLE_SIZE-1:0] bufs [2];
    logic                     wr_sel;
    logic [IW-1:0]            wr_idx;

    assign in_ready = !reset && !full[wr_sel];
    assign frame    = bufs[rd_sel];

    // fill and release always address different buffers, so both may update full[] in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= '0;
        end else begin
            if (in_valid && in_ready) begin
                bufs[wr_sel][wr_idx*SAMPLE_SIZE +: SAMPLE_SIZE] <= in_sample;
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == IW'(N - 1)) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                end
            end
            if (release_rd) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

endmodule

// File: rtl/fft_stream_engine.sv
// fft_stream_engine: streaming frame buffer -> FFT -> partial magnitude, one bin per output beat
module fft_stream_engine
    import fft_pkg::*;
#(
    parameter int SAMPLE_SIZE    = DEF_SAMPLE_SIZE,
    parameter int BUFFER_SIZE    = DEF_BUFFER_SIZE,
    parameter int TWIDDLE_SIZE   = DEF_TWIDDLE_SIZE,
    parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES,
    parameter int FCNT_SIZE      = DEF_FCNT_SIZE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SAMPLE_SIZE-1:0]         in_sample,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           half_spectrum,
    output logic [SAMPLE_SIZE-1:0]         out_mag,
    output logic [$clog2(BUFFER_SIZE)-1:0] out_bin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [FCNT_SIZE-1:0]           frame_count
);

    localparam int N   = BUFFER_SIZE;
    localparam int BW  = $clog2(N);
    localparam int ACC = SAMPLE_SIZE + BW + 2;
    localparam int CW  = $clog2(COMPUTE_CYCLES + 1);

    engine_state_t            state;
    logic [N*TWIDDLE_SIZE-1:0] tw_cos;
    logic [N*TWIDDLE_SIZE-1:0] tw_sin;
    logic [N*SAMPLE_SIZE-1:0]  frame;
    logic [N*SAMPLE_SIZE-1:0]  core_in;
    logic [N*ACC-1:0]          core_re;
    logic [N*ACC-1:0]          core_im;
    logic [N*SAMPLE_SIZE-1:0]  core_mag;
    logic [N*SAMPLE_SIZE-1:0]  result;
    logic [1:0]                full;
    logic                      rd_sel;
    logic                      mode;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             bin;
    logic [BW-1:0]             last;
    logic                      capture;

    fft_pingpong_buffer #(.N(N), .SAMPLE_SIZE(SAMPLE_SIZE)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .release_rd (capture),
        .frame      (frame),
        .full       (full),
        .rd_sel     (rd_sel)
    );

    Twiddle_Storage #(.N(N), .TWIDDLE_SIZE(TWIDDLE_SIZE)) u_tw (
        .tw_cos (tw_cos),
        .tw_sin (tw_sin)
    );

    FFT_N_Point #(.N(N), .SAMPLE_SIZE(SAMPLE_SIZE), .TWIDDLE_SIZE(TWIDDLE_SIZE), .ACC_SIZE(ACC)) u_fft (
        .samples (core_in),
        .tw_cos  (tw_cos),
        .tw_sin  (tw_sin),
        .re      (core_re),
        .im      (core_im)
    );

    Partial_Magnitude_Computer #(.N(N), .ACC_SIZE(ACC), .MAG_SIZE(SAMPLE_SIZE)) u_mag (
        .re  (core_re),
        .im  (core_im),
        .mag (core_mag)
    );

    assign capture  = (state == COMPUTE) && (cnt == CW'(COMPUTE_CYCLES - 1));
    assign last     = BW'(last_bin(mode, N));
    assign out_bin  = bin;
    assign out_mag  = result[bin*SAMPLE_SIZE +: SAMPLE_SIZE];
    assign out_last = out_valid && (bin == last);

    // core input is held for COMPUTE_CYCLES before capture; capture frees the read buffer for refilling
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            core_in     <= '0;
            mode        <= 1'b0;
            cnt         <= '0;
            result      <= '0;
            bin         <= '0;
            out_valid   <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: if (full[rd_sel]) state <= LOAD;
                LOAD: begin
                    core_in <= frame;
                    mode    <= half_spectrum;
                    cnt     <= '0;
                    state   <= COMPUTE;
                end
                COMPUTE: begin
                    cnt <= cnt + 1'b1;
                    if (capture) begin
                        result    <= core_mag;
                        bin       <= '0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: if (out_ready) begin
                    if (bin == last) begin
                        frame_count <= frame_count + 1'b1;
                        out_valid   <= 1'b0;
                        bin         <= '0;
                        state       <= full[rd_sel] ? LOAD : IDLE;
                    end else begin
                        bin <= bin + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stream_engine.sv
// tb_fft_stream_engine: directed frames checked against a DFT reference model and hand-computed values
module tb_fft_stream_engine;

    localparam int S  = 16;
    localparam int N  = 8;
    localparam int T  = 16;
    localparam int CC = 2;
    localparam int FW = 16;
    localparam int BW = 3;

    typedef struct {
        int mag;
        int bin;
        bit last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [S-1:0]  in_sample = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          half_spectrum = 1'b0;
    logic [S-1:0]  out_mag;
    logic [BW-1:0] out_bin;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [FW-1:0] frame_count;

    int    total = 0;
    int    bad = 0;
    int    mcount = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    part[$];
    bit    prev_stall = 1'b0;
    beat_t prev;
    beat_t me;
    beat_t mg;

    always #5 clk = ~clk;

    fft_stream_engine #(
        .SAMPLE_SIZE(S), .BUFFER_SIZE(N), .TWIDDLE_SIZE(T), .COMPUTE_CYCLES(CC), .FCNT_SIZE(FW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_sample     (in_sample),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .half_spectrum (half_spectrum),
        .out_mag       (out_mag),
        .out_bin       (out_bin),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .frame_count   (frame_count)
    );

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int twid(input int idx, input bit use_sin);
        real a = 2.0 * 3.14159265358979323846 * idx / N;
        return int'($floor((use_sin ? $sin(a) : $cos(a)) * 32767.0 + 0.5));
    endfunction

    function automatic longint tmul(input longint x, input int w);
        return (x * w + 16384) >>> 15;
    endfunction

    // reference DFT of the completed frame in part[], queued as expected beats
    task automatic model_frame(input bit half);
        int lastk = half ? N / 2 : N - 1;
        for (int k = 0; k <= lastk; k++) begin
            longint re = 0;
            longint im = 0;
            beat_t  b;
            for (int n = 0; n < N; n++) begin
                re += tmul(part[n], twid((n * k) % N, 1'b0));
                im -= tmul(part[n], twid((n * k) % N, 1'b1));
            end
            b.mag  = int'((re * re + im * im) & 64'hFFFF);
            b.bin  = k;
            b.last = (k == lastk);
            exp_q.push_back(b);
        end
    endtask

    // scoreboard: rebuild frames from accepted samples, check every beat, hold behaviour and frame_count
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            part.delete();
            mcount = 0;
            prev_stall = 1'b0;
        end else begin
            check("frame_count", frame_count, mcount);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_mag", out_mag, prev.mag);
                check("hold_bin", out_bin, prev.bin);
                check("hold_last", out_last, prev.last);
            end
            if (in_valid && in_ready) begin
                part.push_back(int'($signed(in_sample)));
                if (part.size() == N) begin
                    model_frame(half_spectrum);
                    part.delete();
                end
            end
            if (out_valid && out_ready) begin
                mg.mag = out_mag;
                mg.bin = out_bin;
                mg.last = out_last;
                got_q.push_back(mg);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    check("mag", out_mag, me.mag);
                    check("bin", out_bin, me.bin);
                    check("last", out_last, me.last);
                    if (me.last) mcount++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev.mag = out_mag;
            prev.bin = out_bin;
            prev.last = out_last;
        end
    end

    task automatic push(input int v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_sample = S'(v);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (got_q.size() < n && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (got_q.size() < n) check("beat_timeout", got_q.size(), n);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int acc;
        // reset state
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_count", frame_count, 0);
        reset = 1'b0;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        // constant +4 full spectrum: only DC = 32 -> 1024
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) push(4);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", lat, CC + 2);
        wait_beats(N);
        check("t2_beats", got_q.size(), N);
        for (int i = 0; i < got_q.size(); i++) begin
            check("t2_bin", got_q[i].bin, i);
            check("t2_mag", got_q[i].mag, i == 0 ? 1024 : 0);
            check("t2_last", got_q[i].last, i == N - 1);
        end
        check("t2_frame_count", frame_count, 1);

        // impulse, half spectrum: bins 0..4 all 4+0j -> 16
        got_q.delete();
        half_spectrum = 1'b1;
        for (int i = 0; i < N; i++) push(i == 0 ? 4 : 0);
        in_valid = 1'b0;
        wait_beats(N / 2 + 1);
        half_spectrum = 1'b0;
        check("t3_beats", got_q.size(), N / 2 + 1);
        for (int i = 0; i < got_q.size(); i++) begin
            check("t3_bin", got_q[i].bin, i);
            check("t3_mag", got_q[i].mag, 16);
            check("t3_last", got_q[i].last, i == N / 2);
        end
        check("t3_frame_count", frame_count, 2);

        // back-pressure: two free buffers absorb exactly 2N samples while the result is held
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) push(i + 1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("t4_first_valid", out_valid, 1);
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_sample = S'(acc * 37 - 200);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        check("t4_accepted", acc, 2 * N);
        check("t4_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        lat = 0;
        while (!in_ready && lat < 100) begin
            tick();
            lat++;
        end
        check("t4_refill_delay", lat, N + CC + 1);
        wait_beats(3 * N);
        check("t4_beats", got_q.size(), 3 * N);
        check("t4_frame_count", frame_count, 5);

        // reset in the middle of a drain
        got_q.delete();
        for (int i = 0; i < N; i++) push(i * 3 - 5);
        in_valid = 1'b0;
        lat = 0;
        while (!(out_valid && out_bin == 3) && lat < 60) begin
            tick();
            lat++;
        end
        check("t5_reached_bin3", out_bin, 3);
        reset = 1'b1;
        tick();
        check("t5_out_valid", out_valid, 0);
        check("t5_frame_count", frame_count, 0);
        reset = 1'b0;
        got_q.delete();
        for (int i = 0; i < N; i++) push(i % 2 == 0 ? 2 : -2);
        in_valid = 1'b0;
        wait_beats(N);
        check("t5_beats", got_q.size(), N);
        check("t5_first_bin", got_q.size() > 0 ? got_q[0].bin : -1, 0);
        check("t5_nyquist_mag", got_q.size() > 4 ? got_q[4].mag : -1, 256);
        check("t5_frame_count_after", frame_count, 1);

        // four back-to-back frames
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        got_q.delete();
        for (int f = 0; f < 4; f++)
            for (int n = 0; n < N; n++) push(f * 10 + n * n - 3);
        in_valid = 1'b0;
        wait_beats(4 * N);
        check("t6_beats", got_q.size(), 4 * N);
        for (int i = 0; i < got_q.size(); i++) begin
            check("t6_bin", got_q[i].bin, i % N);
            check("t6_last", got_q[i].last, i % N == N - 1);
        end
        check("t6_frame_count", frame_count, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
